// File: rtl/blit_sequencer.sv
// Walks a command list in memory, programs the blitter per record, and polls it to completion.
// One master access in flight at a time, strobes held through waitrequest; IRQ output under BLIT_SEQ_IRQ_EN.
module blit_sequencer #(
  parameter logic [31:0] BLITTER_BASE = 32'h0000_0000,
  parameter int          CMD_WORDS    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avalon_slave_address,
  input  logic        avalon_slave_read,
  input  logic        avalon_slave_write,
  input  logic [31:0] avalon_slave_writedata,
  output logic [31:0] avalon_slave_readdata,
  output logic [31:0] avalon_master_address,
  output logic [3:0]  avalon_master_byteenable,
  output logic [3:0]  avalon_master_burstcount,
  output logic        avalon_master_read,
  output logic        avalon_master_write,
  output logic [31:0] avalon_master_writedata,
  input  logic [31:0] avalon_master_readdata,
  input  logic        avalon_master_readdatavalid,
`ifdef BLIT_SEQ_IRQ_EN
  output logic        irq,
`endif
  input  logic        avalon_master_waitrequest
);

  localparam int            WW     = $clog2(CMD_WORDS);
  localparam logic [WW-1:0] W_LAST = WW'(CMD_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, FETCH_WAIT, PROG, KICK, POLL, POLL_WAIT, NEXT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] w_q, w_d;
  logic [15:0]   cmd_q, cmd_d;
  logic [15:0]   cmd_count_q, cmd_count_d;
  logic [15:0]   done_count_q, done_count_d;
  logic [31:0]   list_base_q, list_base_d;
  logic          busy_q, busy_d;
  logic          go_q, go_d;
  logic          abort_q, abort_d;
  logic [31:0]   readdata_q, readdata_d;
  logic [31:0]   buf_q [CMD_WORDS];
  logic [31:0]   buf_d [CMD_WORDS];
  logic          irq_rd;

`ifdef BLIT_SEQ_IRQ_EN
  logic irq_q, irq_d;
  assign irq    = irq_q;
  assign irq_rd = irq_q;
`else
  assign irq_rd = 1'b0;
`endif

  assign avalon_slave_readdata    = readdata_q;
  assign avalon_master_burstcount = 4'd1;

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    cmd_d         = cmd_q;
    cmd_count_d   = cmd_count_q;
    done_count_d  = done_count_q;
    list_base_d   = list_base_q;
    busy_d        = busy_q;
    go_d          = go_q;
    abort_d       = abort_q;
    buf_d         = buf_q;
    readdata_d    = 32'h0;
`ifdef BLIT_SEQ_IRQ_EN
    irq_d         = irq_q;
`endif
    avalon_master_address    = 32'h0;
    avalon_master_byteenable = 4'h0;
    avalon_master_read       = 1'b0;
    avalon_master_write      = 1'b0;
    avalon_master_writedata  = 32'h0;

    if (avalon_slave_read) begin
      case (avalon_slave_address)
        2'd0:    readdata_d = {28'd0, irq_rd, abort_q, busy_q, go_q};
        2'd1:    readdata_d = list_base_q;
        2'd2:    readdata_d = {16'd0, cmd_count_q};
        default: readdata_d = {16'd0, done_count_q};
      endcase
    end

    if (avalon_slave_write) begin
      case (avalon_slave_address)
        2'd0: begin
          if (!busy_q) begin
            go_d    = avalon_slave_writedata[0];
            abort_d = avalon_slave_writedata[2];
          end else if (avalon_slave_writedata[2]) begin
            abort_d = 1'b1;
          end
`ifdef BLIT_SEQ_IRQ_EN
          if (avalon_slave_writedata[3]) irq_d = 1'b0;
`endif
        end
        2'd1:    if (!busy_q) list_base_d = avalon_slave_writedata;
        2'd2:    if (!busy_q) cmd_count_d = avalon_slave_writedata[15:0];
        default: ;
      endcase
    end

    // FSM comes after the CPU write decode so DONE's clears take priority.
    case (state_q)
      IDLE: begin
        if (go_q) begin
          busy_d       = 1'b1;
          done_count_d = 16'd0;
          cmd_d        = 16'd0;
          w_d          = '0;
          state_d      = (cmd_count_q == 16'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        avalon_master_read       = 1'b1;
        avalon_master_byteenable = 4'hF;
        avalon_master_address    = list_base_q +
            ((32'(cmd_q) * 32'(CMD_WORDS) + 32'(w_q)) << 2);
        if (!avalon_master_waitrequest) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (avalon_master_readdatavalid) begin
          buf_d[w_q] = avalon_master_readdata;
          if (w_q == W_LAST) begin
            w_d     = '0;
            state_d = PROG;
          end else begin
            w_d     = w_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      PROG: begin
        avalon_master_write      = 1'b1;
        avalon_master_byteenable = 4'hF;
        avalon_master_address    = BLITTER_BASE + ((32'(w_q) + 32'd1) << 2);
        avalon_master_writedata  = buf_q[w_q];
        if (!avalon_master_waitrequest) begin
          if (w_q == W_LAST) begin
            w_d     = '0;
            state_d = KICK;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end
      KICK: begin
        avalon_master_write      = 1'b1;
        avalon_master_byteenable = 4'hF;
        avalon_master_address    = BLITTER_BASE;
        avalon_master_writedata  = 32'h1;
        if (!avalon_master_waitrequest) state_d = POLL;
      end
      POLL: begin
        avalon_master_read       = 1'b1;
        avalon_master_byteenable = 4'hF;
        avalon_master_address    = BLITTER_BASE;
        if (!avalon_master_waitrequest) state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (avalon_master_readdatavalid)
          state_d = avalon_master_readdata[0] ? POLL : NEXT;
      end
      NEXT: begin
        done_count_d = done_count_q + 16'd1;
        cmd_d        = cmd_q + 16'd1;
        state_d      = ((cmd_q + 16'd1 == cmd_count_q) || abort_q) ? DONE : FETCH;
      end
      DONE: begin
        busy_d  = 1'b0;
        go_d    = 1'b0;
        abort_d = 1'b0;
`ifdef BLIT_SEQ_IRQ_EN
        irq_d   = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      w_q          <= '0;
      cmd_q        <= 16'd0;
      cmd_count_q  <= 16'd0;
      done_count_q <= 16'd0;
      list_base_q  <= 32'h0;
      busy_q       <= 1'b0;
      go_q         <= 1'b0;
      abort_q      <= 1'b0;
      readdata_q   <= 32'h0;
      for (int i = 0; i < CMD_WORDS; i++) buf_q[i] <= 32'h0;
`ifdef BLIT_SEQ_IRQ_EN
      irq_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      cmd_q        <= cmd_d;
      cmd_count_q  <= cmd_count_d;
      done_count_q <= done_count_d;
      list_base_q  <= list_base_d;
      busy_q       <= busy_d;
      go_q         <= go_d;
      abort_q      <= abort_d;
      readdata_q   <= readdata_d;
      buf_q        <= buf_d;
`ifdef BLIT_SEQ_IRQ_EN
      irq_q        <= irq_d;
`endif
    end
  end

endmodule

// File: doc/blit_sequencer.md
BLIT_SEQUENCER -- requirements
Module: blit_sequencer

Interface
REQ-001 Parameter: BLITTER_BASE, 32'h0000_0000, byte base address of the blitter register window on the master bus.
REQ-002 Parameter: CMD_WORDS, 6, words per command record (frame addr, sprite addr, dims, xy, startxy, endxy).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 avalon_slave_address  input  2  control register select.
REQ-006 avalon_slave_read / avalon_slave_write  input  1 each  CPU register access strobes.
REQ-007 avalon_slave_writedata  input  32 / avalon_slave_readdata  output  32  CPU register data.
REQ-008 avalon_master_address  output  32  byte address; avalon_master_byteenable  output  4; avalon_master_burstcount  output  4, constant 1.
REQ-009 avalon_master_read / avalon_master_write  output  1  bus strobes, held until waitrequest low.
REQ-010 avalon_master_writedata  output  32; avalon_master_readdata  input  32; avalon_master_readdatavalid / avalon_master_waitrequest  input  1.

Function
REQ-011 Slave registers: 0 CTRL (bit0 GO, bit1 BUSY read-only, bit2 ABORT), 1 LIST_BASE, 2 CMD_COUNT (16 bits), 3 DONE_COUNT (read-only, 16 bits).
REQ-012 Slave readdata registered, valid one cycle after read; unmapped bits read 0.
REQ-013 States: IDLE, FETCH, FETCH_WAIT, PROG, KICK, POLL, POLL_WAIT, NEXT, DONE.
REQ-014 IDLE: GO=1 latches LIST_BASE and CMD_COUNT, clears DONE_COUNT, sets BUSY; CMD_COUNT=0 goes straight to DONE.
REQ-015 FETCH: read LIST_BASE + (cmd*CMD_WORDS + w)*4, byteenable 4'b1111; read held while waitrequest=1, dropped the cycle after it is low.
REQ-016 FETCH_WAIT: the readdatavalid word is stored in buffer[w]; w<5 returns to FETCH with w+1, else PROG with w=0.
REQ-017 PROG: write buffer[w] to BLITTER_BASE + (w+1)*4, held while waitrequest=1; w<5 repeats, else KICK.
REQ-018 KICK: write 32'h1 to BLITTER_BASE + 0, then POLL.
REQ-019 POLL/POLL_WAIT: read BLITTER_BASE + 0; readdata bit0=1 repeats POLL, bit0=0 goes to NEXT.
REQ-020 NEXT: DONE_COUNT+1, cmd+1; cmd+1 = count or ABORT set goes to DONE, else FETCH.
REQ-021 DONE: BUSY cleared and GO cleared in the same cycle, then IDLE.
REQ-022 ABORT is sampled only in NEXT; an in-flight blit always completes; ABORT self-clears in DONE.
REQ-023 CPU writes to LIST_BASE/CMD_COUNT while BUSY are ignored; writing GO while BUSY has no effect.
REQ-024 CPU write to CTRL and a DONE clear of GO in the same cycle: the DONE clear wins.
REQ-025 At most one master transaction outstanding; read and write are never asserted together.
REQ-026 Address arithmetic is 32-bit and wraps modulo 2^32.

Reset
REQ-027 While reset=0: state IDLE, all registers 0, avalon_master_read/write 0, address/writedata/byteenable 0, burstcount 1, slave readdata 0.
REQ-028 Reset mid-transaction drops the strobes immediately; a readdatavalid arriving after release in IDLE is ignored.

Configuration
REQ-029 Macro BLIT_SEQ_IRQ_EN defined: adds output irq (1 bit), set in DONE, cleared by a CPU write of 1 to CTRL bit3; reset 0.
REQ-030 Macro BLIT_SEQ_IRQ_EN undefined: no irq port; CTRL bit3 reads 0 and writes are ignored.

Verification
REQ-031 LIST_BASE=0x1000, CMD_COUNT=1, GO -> 6 reads at 0x1000..0x1014, 6 writes at BLITTER_BASE+4..+24 with the same data, a write of 1 to +0, polls, DONE_COUNT=1, BUSY=0.
REQ-032 CMD_COUNT=0, GO -> no master traffic; BUSY drops within 2 cycles.
REQ-033 waitrequest held 3 cycles on each access, blitter bit0 busy for 10 polls -> no strobe dropped early, data unchanged, one command completed.
REQ-034 CMD_COUNT=3, ABORT written during the first poll -> DONE_COUNT=1, second command not fetched.
REQ-035 reset=0 asserted during PROG -> strobes low asynchronously; after release, register 0 reads 0 and no traffic occurs.
REQ-036 BLIT_SEQ_IRQ_EN build, 2 commands -> irq=1 after the second; CTRL bit3 write -> irq=0.
